// File: rtl/arb2_mux_ctrl.sv
// rtl/arb2_mux_ctrl.sv - two-source round-robin burst arbiter driving a 9-bit 2:1 mux into a one-beat output slot
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   a_valid/a_data/a_last/a_ready source A beat stream (9-bit beats)
//   b_valid/b_data/b_last/b_ready source B beat stream (9-bit beats)
//   out_valid/out_data/out_last/out_ready  registered output slot to the consumer
//   sel                           registered mux select, 0 = A, 1 = B
//   burst_cut                     one-cycle pulse after a grant is released by the beat cap

module arb2_mux_ctrl #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    input  logic [8:0] a_data,
    input  logic       a_last,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [8:0] b_data,
    input  logic       b_last,
    output logic       b_ready,
    output logic       out_valid,
    output logic [8:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       sel,
    output logic       burst_cut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              prio;
    logic              prio_next;
    logic              sel_next;
    logic [CNT_W-1:0]  cnt;

    logic              own_valid;
    logic [8:0]        own_data;
    logic              own_last;
    logic              own_ready;
    logic              xfer;
    logic              at_cap;
    logic              rel;

    // sel is registered together with the state, so it always names the owner
    // while a grant is held and can steer the mux directly.
    assign own_valid = sel ? b_valid : a_valid;
    assign own_data  = sel ? b_data  : a_data;
    assign own_last  = sel ? b_last  : a_last;

    // Ready is held low while reset is asserted so no beat is accepted on the reset edge.
    assign own_ready = (state != IDLE) && !rst && (!out_valid || out_ready);
    assign a_ready   = own_ready && (state == OWN_A);
    assign b_ready   = own_ready && (state == OWN_B);

    assign xfer   = own_valid && own_ready;
    // The beat being transferred now is the one that brings the count to the cap.
    assign at_cap = (cnt == CNT_W'(MAX_BEATS - 1));
    assign rel    = xfer && (own_last || at_cap);

    always_comb begin
        state_next = state;
        sel_next   = sel;
        prio_next  = prio;
        case (state)
            IDLE: begin
                if (a_valid && (!b_valid || !prio)) begin
                    state_next = OWN_A;
                    sel_next   = 1'b0;
                end else if (b_valid) begin
                    state_next = OWN_B;
                    sel_next   = 1'b1;
                end
            end
            OWN_A, OWN_B: begin
                if (rel) begin
                    state_next = IDLE;
                    // Favour the other source on the next contended arbitration.
                    prio_next  = (state == OWN_A);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            sel       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 9'd0;
            out_last  <= 1'b0;
            cnt       <= '0;
            burst_cut <= 1'b0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
            prio  <= prio_next;

            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= own_data;
                out_last  <= own_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (rel) begin
                cnt <= '0;
            end else if (xfer) begin
                cnt <= cnt + CNT_W'(1);
            end

            // A release without last can only come from the cap.
            burst_cut <= rel && !own_last;
        end
    end

endmodule

// File: tb/tb_arb2_mux_ctrl.sv
// tb/tb_arb2_mux_ctrl.sv - scoreboard bench for arb2_mux_ctrl with MAX_BEATS=4

module tb_arb2_mux_ctrl;

    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_last, a_ready;
    logic [8:0] a_data;
    logic       b_valid, b_last, b_ready;
    logic [8:0] b_data;
    logic       out_valid, out_last, out_ready;
    logic [8:0] out_data;
    logic       sel, burst_cut;

    arb2_mux_ctrl #(.MAX_BEATS(MB), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_last    (a_last),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_last    (b_last),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .burst_cut (burst_cut)
    );

    always #5 clk = ~clk;

    logic [9:0] a_q[$];
    logic [9:0] b_q[$];
    logic [9:0] exp_q[$];
    bit         a_en = 1'b1;
    bit         b_en = 1'b1;
    int         checks = 0;
    int         errors = 0;
    logic [9:0] want;

    // Scoreboard: every beat leaving the output slot must match the next expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra got=%h last=%0b want=none", out_data, out_last);
            end else begin
                want = exp_q.pop_front();
                if ({out_last, out_data} !== want) begin
                    errors++;
                    $display("FAIL scoreboard_beat got=%h last=%0b want=%h last=%0b",
                             out_data, out_last, want[8:0], want[9]);
                end
            end
        end
    end

    task automatic drive_srcs();
        logic [9:0] h;
        h = (a_q.size() != 0) ? a_q[0] : 10'd0;
        a_valid = a_en && (a_q.size() != 0);
        a_last  = h[9];
        a_data  = h[8:0];
        h = (b_q.size() != 0) ? b_q[0] : 10'd0;
        b_valid = b_en && (b_q.size() != 0);
        b_last  = h[9];
        b_data  = h[8:0];
    endtask

    // Advance one clock; source queues advance on observed handshakes.
    task automatic step();
        logic af, bf;
        @(negedge clk);
        af = a_valid && a_ready;
        bf = b_valid && b_ready;
        @(posedge clk);
        #1;
        if (af && a_q.size() != 0) a_q.delete(0);
        if (bf && b_q.size() != 0) b_q.delete(0);
        drive_srcs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_q.delete();
        b_q.delete();
        exp_q.delete();
        a_en = 1'b1;
        b_en = 1'b1;
        out_ready = 1'b1;
        drive_srcs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        a_q.push_back(10'h055);
        b_q.push_back(10'h066);
        rst = 1'b1;
        drive_srcs();
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 9'd0) begin errors++; $display("FAIL rst_out_data got=%h want=000", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b want=0", out_last); end
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL rst_sel got=%b want=0", sel); end
        checks++; if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b want=00", {a_ready, b_ready}); end
        checks++; if (burst_cut !== 1'b0) begin errors++; $display("FAIL rst_burst_cut got=%b want=0", burst_cut); end
        checks++; if (dut.state !== 2'd0 || dut.prio !== 1'b0 || dut.cnt !== 8'd0) begin
            errors++; $display("FAIL rst_internal state=%0d prio=%b cnt=%0d want 0/0/0", dut.state, dut.prio, dut.cnt);
        end
        do_reset();
    endtask

    task automatic test_single();
        int nv = 0;
        do_reset();
        a_q = '{10'h101, 10'h102, 10'h303};
        exp_q = '{10'h101, 10'h102, 10'h303};
        drive_srcs();
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL single_idle_ready got=%b want=0", a_ready); end
        step();
        checks++; if (a_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_grant_latency ready=%b out_valid=%b want 1/0", a_ready, out_valid);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) begin
                nv++;
                checks++; if (sel !== 1'b0) begin errors++; $display("FAIL single_sel got=%b want=0", sel); end
            end
        end
        checks++; if (nv !== 3) begin errors++; $display("FAIL single_beat_cycles got=%0d want=3", nv); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing got=%0d left want=0", exp_q.size()); end
        checks++; if (dut.state !== 2'd0 || dut.prio !== 1'b1) begin
            errors++; $display("FAIL single_release state=%0d prio=%b want 0/1", dut.state, dut.prio);
        end
    endtask

    task automatic test_contention();
        int viol = 0;
        int first_owner = -1;
        do_reset();
        a_q = '{10'h0AA, 10'h2AB};
        b_q = '{10'h1BB, 10'h3BC};
        exp_q = '{10'h0AA, 10'h2AB, 10'h1BB, 10'h3BC};
        drive_srcs();
        for (int i = 0; i < 20; i++) begin
            step();
            if (first_owner < 0 && dut.state !== 2'd0) first_owner = int'(dut.state);
            if (dut.state === 2'd1 && (b_ready !== 1'b0 || sel !== 1'b0)) viol++;
            if (dut.state === 2'd2 && sel !== 1'b1) viol++;
        end
        checks++; if (first_owner !== 1) begin errors++; $display("FAIL contention_first_owner got=%0d want=1", first_owner); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL contention_sel_ready got=%0d violations want=0", viol); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL contention_missing got=%0d left want=0", exp_q.size()); end
        checks++; if (dut.prio !== 1'b0) begin errors++; $display("FAIL contention_prio got=%b want=0", dut.prio); end
    endtask

    task automatic test_backpressure();
        logic [8:0] hold;
        int guard = 0;
        do_reset();
        a_q = '{10'h111, 10'h112, 10'h313};
        exp_q = '{10'h111, 10'h112, 10'h313};
        drive_srcs();
        while (!out_valid && guard < 10) begin
            step();
            guard++;
        end
        out_ready = 1'b0;
        hold = out_data;
        checks++; if (hold !== 9'h111) begin errors++; $display("FAIL bp_first_beat got=%h want=111", hold); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== hold || a_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold valid=%b data=%h ready=%b want 1/%h/0", out_valid, out_data, a_ready, hold);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        checks++; if (exp_q.size() != 0 || a_q.size() != 0) begin
            errors++; $display("FAIL bp_drain got exp=%0d src=%0d left want 0/0", exp_q.size(), a_q.size());
        end
    endtask

    task automatic test_cap();
        int cuts = 0;
        int guard = 0;
        do_reset();
        a_en = 1'b0;
        a_q = '{10'h0A1, 10'h2A2};
        b_q = '{10'h1B1, 10'h1B2, 10'h1B3, 10'h1B4, 10'h1B5, 10'h1B6};
        exp_q = '{10'h1B1, 10'h1B2, 10'h1B3, 10'h1B4, 10'h0A1, 10'h2A2, 10'h1B5, 10'h1B6};
        drive_srcs();
        while (dut.state !== 2'd2 && guard < 10) begin
            step();
            guard++;
        end
        a_en = 1'b1;
        drive_srcs();
        for (int i = 0; i < 30; i++) begin
            step();
            if (burst_cut === 1'b1) cuts++;
        end
        checks++; if (cuts !== 1) begin errors++; $display("FAIL cap_cut_pulses got=%0d want=1", cuts); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cap_missing got=%0d left want=0", exp_q.size()); end
        checks++; if (dut.state !== 2'd2 || dut.cnt !== 8'd2) begin
            errors++; $display("FAIL cap_resume state=%0d cnt=%0d want 2/2", dut.state, dut.cnt);
        end
    endtask

    task automatic test_cap_last();
        int cuts = 0;
        do_reset();
        a_q = '{10'h0C1, 10'h0C2, 10'h0C3, 10'h2C4};
        exp_q = '{10'h0C1, 10'h0C2, 10'h0C3, 10'h2C4};
        drive_srcs();
        for (int i = 0; i < 15; i++) begin
            step();
            if (burst_cut === 1'b1) cuts++;
        end
        checks++; if (cuts !== 0) begin errors++; $display("FAIL caplast_cut got=%0d want=0", cuts); end
        checks++; if (dut.state !== 2'd0 || dut.prio !== 1'b1 || exp_q.size() != 0) begin
            errors++; $display("FAIL caplast_release state=%0d prio=%b left=%0d want 0/1/0", dut.state, dut.prio, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        do_reset();
        a_q = '{10'h121, 10'h122, 10'h123, 10'h324};
        exp_q = '{10'h121, 10'h122, 10'h123, 10'h324};
        drive_srcs();
        while (!(out_valid && out_data === 9'h122) && guard < 10) begin
            step();
            guard++;
        end
        checks++; if (out_data !== 9'h122) begin errors++; $display("FAIL rmid_second_beat got=%h want=122", out_data); end
        rst = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst got=%b want=0", a_ready); end
        step();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || sel !== 1'b0 || {a_ready, b_ready} !== 2'b00) begin
            errors++; $display("FAIL rmid_outputs valid=%b sel=%b ready=%b want 0/0/00", out_valid, sel, {a_ready, b_ready});
        end
        checks++; if (dut.state !== 2'd0 || dut.prio !== 1'b0) begin
            errors++; $display("FAIL rmid_internal state=%0d prio=%b want 0/0", dut.state, dut.prio);
        end
        a_q.delete();
        exp_q.delete();
        drive_srcs();
        step();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive_srcs();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_cap();
        test_cap_last();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
